// File: rtl/nano_viewer_pkg.sv
// Shared definitions for the picture memory path: arbiter state encoding,
// PSRAM command codes and default bus geometry.
package nano_viewer_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_GAP  = 3'd4
    } arb_state_t;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BURST  = 16;

    // Counter width that can hold the value n without wrapping (min 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/psram_arb_pick.sv
// Read/write grant decision with a write-starvation counter.
// Combinational pick, counter updates on the granting edge.
module psram_arb_pick
    import nano_viewer_pkg::*;
#(
    parameter int WR_STARVE = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_arb_en,
    input  logic i_rd_req,
    input  logic i_wr_req,
    output logic pick_rd,
    output logic pick_wr
);

    localparam int SW = cnt_width(WR_STARVE);
    localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE);

    logic [SW-1:0] r_starve_cnt;
    logic          w_wr_win;

    // Reads win ties until the write has watched WR_STARVE read grants go by.
    assign w_wr_win = i_wr_req && (!i_rd_req || (r_starve_cnt == STARVE_MAX));
    assign pick_wr  = i_arb_en && w_wr_win;
    assign pick_rd  = i_arb_en && i_rd_req && !w_wr_win;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (pick_wr) begin
            r_starve_cnt <= '0;
        end else if (pick_rd && i_wr_req && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Shares the PSRAM command port between display line reads and picture writes,
// one fixed burst per grant followed by a turnaround gap.
module psram_arbiter
    import nano_viewer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BURST      = DEF_BURST,
    parameter int GAP_CYC    = 4,
    parameter int WR_STARVE  = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_calib,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_gnt,
    output logic              wr_data_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic              mem_cmd,
    output logic              mem_cmd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              err_timeout
);

    localparam int BW = cnt_width(BURST);
    localparam int GW = cnt_width(GAP_CYC);
    localparam int TW = cnt_width(RD_TIMEOUT);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);

    arb_state_t        r_state;
    logic [BW-1:0]     r_beat;
    logic [GW-1:0]     r_gap;
    logic [TW-1:0]     r_tmo;
    logic [ADDR_W-1:0] r_wr_addr;

    logic w_arb_en;
    logic w_pick_rd;
    logic w_pick_wr;

    assign w_arb_en = (r_state == ST_IDLE) && init_calib;

    psram_arb_pick #(
        .WR_STARVE (WR_STARVE)
    ) u_pick (
        .i_clk    (sys_clk),
        .i_rst    (sys_rst),
        .i_arb_en (w_arb_en),
        .i_rd_req (rd_req),
        .i_wr_req (wr_req),
        .pick_rd  (w_pick_rd),
        .pick_wr  (w_pick_wr)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_INIT;
            r_beat      <= '0;
            r_gap       <= '0;
            r_tmo       <= '0;
            r_wr_addr   <= '0;
            rd_gnt      <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_done     <= 1'b0;
            wr_gnt      <= 1'b0;
            wr_data_req <= 1'b0;
            wr_done     <= 1'b0;
            mem_cmd     <= CMD_RD;
            mem_cmd_en  <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            err_timeout <= 1'b0;
        end else begin
            rd_gnt     <= 1'b0;
            wr_gnt     <= 1'b0;
            rd_done    <= 1'b0;
            wr_done    <= 1'b0;
            rd_valid   <= 1'b0;
            mem_cmd_en <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    if (init_calib) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (!init_calib) begin
                        r_state <= ST_INIT;
                    end else if (w_pick_wr) begin
                        r_state     <= ST_WR;
                        r_beat      <= '0;
                        r_wr_addr   <= wr_addr;
                        wr_gnt      <= 1'b1;
                        wr_data_req <= 1'b1;
                    end else if (w_pick_rd) begin
                        r_state    <= ST_RD;
                        r_beat     <= '0;
                        r_tmo      <= '0;
                        rd_gnt     <= 1'b1;
                        mem_cmd_en <= 1'b1;
                        mem_cmd    <= CMD_RD;
                        mem_addr   <= rd_addr;
                    end
                end

                ST_RD: begin
                    r_tmo <= r_tmo + TW'(1);
                    // A last beat landing on the timeout cycle still completes normally.
                    if (mem_rd_valid && (r_beat == BEAT_LAST)) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem_rd_data;
                        rd_done  <= 1'b1;
                        r_beat   <= r_beat + BW'(1);
                        r_gap    <= '0;
                        r_state  <= ST_GAP;
                    end else if (r_tmo == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        rd_done     <= 1'b1;
                        r_gap       <= '0;
                        r_state     <= ST_GAP;
                    end else if (mem_rd_valid) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem_rd_data;
                        r_beat   <= r_beat + BW'(1);
                    end
                end

                ST_WR: begin
                    // FWFT source: the word is already on wr_data while we pop it.
                    mem_wr_data <= wr_data;
                    r_beat      <= r_beat + BW'(1);
                    if (r_beat == '0) begin
                        mem_cmd_en <= 1'b1;
                        mem_cmd    <= CMD_WR;
                        mem_addr   <= r_wr_addr;
                    end
                    if (r_beat == BEAT_LAST) begin
                        wr_data_req <= 1'b0;
                        wr_done     <= 1'b1;
                        r_gap       <= '0;
                        r_state     <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end

                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
